// File: rtl/octal_pkg.sv
// Shared types for the digit-serial octal arithmetic blocks.
package octal_pkg;

  localparam int unsigned OCT_DIGIT_W = 3;

  typedef logic [OCT_DIGIT_W-1:0] oct_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } oct_ser_state_e;

endpackage

// File: rtl/octal_digit_add.sv
// One octal digit adder: digit + digit + carry-in -> digit + carry-out.
module octal_digit_add
  import octal_pkg::*;
(
  input  oct_digit_t x,
  input  oct_digit_t y,
  input  logic       ci,
  output oct_digit_t s,
  output logic       co
);

  assign {co, s} = 4'(x) + 4'(y) + 4'(ci);

endmodule

// File: rtl/octal_serial_add.sv
// Digit-serial octal adder: one digit per clock, LSD first, valid/ready on both sides.
module octal_serial_add
  import octal_pkg::*;
#(
  parameter int unsigned DIGITS = 2
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OCT_DIGIT_W*DIGITS-1:0] a,
  input  logic [OCT_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OCT_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout
);

  localparam int unsigned W     = OCT_DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  oct_ser_state_e   state, state_n;
  logic [W-1:0]     opa, opb;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             accept;
  oct_digit_t       dig_a, dig_b, dig_s;
  logic             dig_co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // in_ready in DONE follows out_ready so a result can hand over straight into a new add.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ADD;
      end
      ADD: begin
        if (idx == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = in_valid ? ADD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign dig_a  = opa[OCT_DIGIT_W*32'(idx) +: OCT_DIGIT_W];
  assign dig_b  = opb[OCT_DIGIT_W*32'(idx) +: OCT_DIGIT_W];

  octal_digit_add u_digit (
    .x  (dig_a),
    .y  (dig_b),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == ADD) begin
      sum[OCT_DIGIT_W*32'(idx) +: OCT_DIGIT_W] <= dig_s;
      carry <= dig_co;
      if (idx == LAST) cout <= dig_co;
      else             idx  <= idx + IDX_W'(1);
    end
  end

endmodule
